snow64_lar_mem_xfer_ctrl: RTL and testbench

// Parametrised LAR shared-data memory transfer controller. It takes dirty-evict and fill

---
 rtl/snow64_lar_mem_xfer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_snow64_lar_mem_xfer_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_lar_mem_xfer_ctrl.sv
// Transfer controller between the LAR file channels and memory: round-robin grant,
// then an optional write-back and an optional fill, with same-address fill forwarding.
module snow64_lar_mem_xfer_ctrl #(
    parameter int DATA_WIDTH      = 256,
    parameter int BASE_ADDR_WIDTH = 59,
    parameter int NUM_CH          = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 ch_req,
    input  logic [NUM_CH-1:0]                 ch_need_wb,
    input  logic [NUM_CH-1:0]                 ch_need_fill,
    input  logic [NUM_CH*BASE_ADDR_WIDTH-1:0] ch_wb_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      ch_wb_data,
    input  logic [NUM_CH*BASE_ADDR_WIDTH-1:0] ch_fill_addr,
    output logic [NUM_CH-1:0]                 ch_done,
    output logic [DATA_WIDTH-1:0]             done_data,
    output logic                              busy,
    output logic                              mem_wr_req,
    output logic [BASE_ADDR_WIDTH-1:0]        mem_wr_base_addr,
    output logic [DATA_WIDTH-1:0]             mem_wr_data,
    input  logic                              mem_wr_valid,
    output logic                              mem_rd_req,
    output logic [BASE_ADDR_WIDTH-1:0]        mem_rd_base_addr,
    input  logic                              mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]             mem_rd_data,
    output logic [1:0]                        dbg_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Memory handshake: a request stays high until the cycle its valid is seen high;
    // the request drops on the following edge. Valid is ignored while its request is low.
    state_t                     state_q;
    logic [IDX_W-1:0]           ptr_q;
    logic [IDX_W-1:0]           grant_q;
    logic                       need_fill_q;
    logic                       bypass_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       mem_wr_req_q;
    logic [BASE_ADDR_WIDTH-1:0] mem_wr_addr_q;
    logic [DATA_WIDTH-1:0]      mem_wr_data_q;
    logic                       mem_rd_req_q;
    logic [BASE_ADDR_WIDTH-1:0] mem_rd_addr_q;

    logic                       gnt_found;
    logic [IDX_W-1:0]           gnt_idx;
    logic [BASE_ADDR_WIDTH-1:0] sel_wb_addr;
    logic [BASE_ADDR_WIDTH-1:0] sel_fill_addr;
    logic [DATA_WIDTH-1:0]      sel_wb_data;
    logic                       sel_bypass;

    // First requester at or after the pointer, wrapping around the channel list.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_found && ch_req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

    assign sel_wb_addr   = ch_wb_addr[gnt_idx*BASE_ADDR_WIDTH +: BASE_ADDR_WIDTH];
    assign sel_fill_addr = ch_fill_addr[gnt_idx*BASE_ADDR_WIDTH +: BASE_ADDR_WIDTH];
    assign sel_wb_data   = ch_wb_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_bypass    = ch_need_wb[gnt_idx] && ch_need_fill[gnt_idx] &&
                           (sel_wb_addr == sel_fill_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            need_fill_q   <= 1'b0;
            bypass_q      <= 1'b0;
            rdata_q       <= '0;
            mem_wr_req_q  <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_rd_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        grant_q     <= gnt_idx;
                        need_fill_q <= ch_need_fill[gnt_idx];
                        bypass_q    <= sel_bypass;
                        // Forwarded line is known now; otherwise start from zero for no-fill requests.
                        rdata_q     <= sel_bypass ? sel_wb_data : '0;
                        if (ch_need_fill[gnt_idx]) mem_rd_addr_q <= sel_fill_addr;
                        if (ch_need_wb[gnt_idx]) begin
                            state_q       <= S_WB;
                            mem_wr_req_q  <= 1'b1;
                            mem_wr_addr_q <= sel_wb_addr;
                            mem_wr_data_q <= sel_wb_data;
                        end else if (ch_need_fill[gnt_idx]) begin
                            state_q      <= S_FILL;
                            mem_rd_req_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WB: begin
                    if (mem_wr_valid) begin
                        mem_wr_req_q <= 1'b0;
                        if (need_fill_q && !bypass_q) begin
                            state_q      <= S_FILL;
                            mem_rd_req_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_rd_valid) begin
                        mem_rd_req_q <= 1'b0;
                        rdata_q      <= mem_rd_data;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (grant_q == IDX_W'(NUM_CH - 1)) ptr_q <= '0;
                    else                               ptr_q <= grant_q + IDX_W'(1);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ch_done = '0;
        if (state_q == S_DONE) ch_done[grant_q] = 1'b1;
    end

    assign done_data        = (state_q == S_DONE) ? rdata_q : '0;
    assign busy             = (state_q != S_IDLE);
    assign mem_wr_req       = mem_wr_req_q;
    assign mem_wr_base_addr = mem_wr_addr_q;
    assign mem_wr_data      = mem_wr_data_q;
    assign mem_rd_req       = mem_rd_req_q;
    assign mem_rd_base_addr = mem_rd_addr_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_snow64_lar_mem_xfer_ctrl.sv
// Directed bench for snow64_lar_mem_xfer_ctrl with NUM_CH=2 and a hand-driven memory.
module tb_snow64_lar_mem_xfer_ctrl;

    localparam int DW = 256;
    localparam int AW = 59;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   ch_req, ch_need_wb, ch_need_fill, ch_done;
    logic [NC*AW-1:0] ch_wb_addr, ch_fill_addr;
    logic [NC*DW-1:0] ch_wb_data;
    logic [DW-1:0]   done_data, mem_wr_data, mem_rd_data;
    logic            busy, mem_wr_req, mem_wr_valid, mem_rd_req, mem_rd_valid;
    logic [AW-1:0]   mem_wr_base_addr, mem_rd_base_addr;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] pat_ab, pat_55, pat_77, pat_rd, pat_a0, pat_b1;

    always #5 clk = ~clk;

    snow64_lar_mem_xfer_ctrl #(
        .DATA_WIDTH(DW), .BASE_ADDR_WIDTH(AW), .NUM_CH(NC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_req(ch_req), .ch_need_wb(ch_need_wb), .ch_need_fill(ch_need_fill),
        .ch_wb_addr(ch_wb_addr), .ch_wb_data(ch_wb_data), .ch_fill_addr(ch_fill_addr),
        .ch_done(ch_done), .done_data(done_data), .busy(busy),
        .mem_wr_req(mem_wr_req), .mem_wr_base_addr(mem_wr_base_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid),
        .mem_rd_req(mem_rd_req), .mem_rd_base_addr(mem_rd_base_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pat_ab = {32{8'hAB}};
        pat_55 = {32{8'h55}};
        pat_77 = {32{8'h77}};
        pat_rd = {8{32'h0123_4567}};
        pat_a0 = {32{8'hA0}};
        pat_b1 = {32{8'hB1}};

        rst_n = 1'b0;
        ch_req = '0; ch_need_wb = '0; ch_need_fill = '0;
        ch_wb_addr = '0; ch_wb_data = '0; ch_fill_addr = '0;
        mem_wr_valid = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        tick(); tick();
        chk("rst_wr_req", 256'(mem_wr_req), 256'(0));
        chk("rst_rd_req", 256'(mem_rd_req), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(ch_done), 256'(0));
        chk("rst_state", 256'(dbg_state), 256'(0));
        rst_n = 1'b1;
        tick();

        // ch0 no-op: done at N+1, pointer moves to 1
        ch_req = 2'b01;
        tick();
        chk("noop0_done", 256'(ch_done), 256'h1);
        chk("noop0_data", done_data, 256'h0);
        tick();
        ch_req = 2'b00;
        chk("noop0_idle", 256'(busy), 256'(0));
        tick();

        // ch1 write-back with memory never answering, then reset mid-WB
        ch_need_wb = 2'b10;
        ch_wb_addr[1*AW +: AW] = 59'h99;
        ch_req = 2'b10;
        tick();
        chk("hang_wr_req", 256'(mem_wr_req), 256'(1));
        chk("hang_busy", 256'(busy), 256'(1));
        tick();
        #2;
        rst_n = 1'b0;
        ch_req = 2'b00; ch_need_wb = 2'b00;
        #1;
        chk("midrst_wr_req", 256'(mem_wr_req), 256'(0));
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_state", 256'(dbg_state), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Both no-op after reset: pointer back at 0, so ch0 first, then ch1
        ch_req = 2'b11;
        tick();
        chk("postrst_first", 256'(ch_done), 256'h1);
        tick();
        ch_req = 2'b10;
        tick();
        chk("postrst_second", 256'(ch_done), 256'h2);
        chk("postrst_data", done_data, 256'h0);
        tick();
        ch_req = 2'b00;
        tick();

        // ch0 fill only, addr 0x10, read data after three wait cycles
        ch_need_wb = 2'b00; ch_need_fill = 2'b01;
        ch_fill_addr[0 +: AW] = 59'h10;
        ch_req = 2'b01;
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("fill_rd_req", 256'(mem_rd_req), 256'(1));
            chk("fill_rd_addr", 256'(mem_rd_base_addr), 256'h10);
            chk("fill_no_wr", 256'(mem_wr_req), 256'(0));
            chk("fill_not_done", 256'(ch_done), 256'h0);
            if (w == 3) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = pat_ab;
            end
        end
        tick();
        mem_rd_valid = 1'b0;
        chk("fill_done", 256'(ch_done), 256'h1);
        chk("fill_data", done_data, pat_ab);
        chk("fill_rd_drop", 256'(mem_rd_req), 256'(0));
        tick();
        ch_req = 2'b00;
        tick();

        // ch1 write-back then fill, zero-wait memory: done at N+3
        ch_need_wb = 2'b10; ch_need_fill = 2'b10;
        ch_wb_addr[1*AW +: AW] = 59'h20;
        ch_wb_data[1*DW +: DW] = pat_55;
        ch_fill_addr[1*AW +: AW] = 59'h30;
        ch_req = 2'b10;
        tick();
        chk("wf_wr_req", 256'(mem_wr_req), 256'(1));
        chk("wf_wr_addr", 256'(mem_wr_base_addr), 256'h20);
        chk("wf_wr_data", mem_wr_data, pat_55);
        chk("wf_no_rd_yet", 256'(mem_rd_req), 256'(0));
        mem_wr_valid = 1'b1;
        tick();
        mem_wr_valid = 1'b0;
        chk("wf_wr_drop", 256'(mem_wr_req), 256'(0));
        chk("wf_rd_req", 256'(mem_rd_req), 256'(1));
        chk("wf_rd_addr", 256'(mem_rd_base_addr), 256'h30);
        chk("wf_not_done", 256'(ch_done), 256'h0);
        mem_rd_valid = 1'b1;
        mem_rd_data  = pat_rd;
        tick();
        mem_rd_valid = 1'b0;
        chk("wf_done", 256'(ch_done), 256'h2);
        chk("wf_data", done_data, pat_rd);
        chk("wf_rd_drop", 256'(mem_rd_req), 256'(0));
        tick();
        ch_req = 2'b00;
        tick();

        // Bypass: ch0 write-back and fill to the same line 0x40
        ch_need_wb = 2'b01; ch_need_fill = 2'b01;
        ch_wb_addr[0 +: AW] = 59'h40;
        ch_fill_addr[0 +: AW] = 59'h40;
        ch_wb_data[0 +: DW] = pat_77;
        ch_req = 2'b01;
        tick();
        chk("byp_wr_req", 256'(mem_wr_req), 256'(1));
        chk("byp_wr_addr", 256'(mem_wr_base_addr), 256'h40);
        mem_wr_valid = 1'b1;
        tick();
        mem_wr_valid = 1'b0;
        chk("byp_no_rd", 256'(mem_rd_req), 256'(0));
        chk("byp_done", 256'(ch_done), 256'h1);
        chk("byp_data", done_data, pat_77);
        tick();
        ch_req = 2'b00;
        chk("byp_no_rd_after", 256'(mem_rd_req), 256'(0));
        tick();

        // Pointer is 1: simultaneous no-ops serve ch1 before ch0
        ch_need_wb = 2'b00; ch_need_fill = 2'b00;
        ch_req = 2'b11;
        tick();
        chk("rr_first_ch1", 256'(ch_done), 256'h2);
        chk("rr_first_data", done_data, 256'h0);
        chk("rr_no_mem", 256'({mem_wr_req, mem_rd_req}), 256'h0);
        tick();
        ch_req = 2'b01;
        tick();
        chk("rr_second_ch0", 256'(ch_done), 256'h1);
        tick();
        ch_req = 2'b00;
        tick();
        ch_req = 2'b10;
        tick();
        chk("noop1_done", 256'(ch_done), 256'h2);
        chk("noop1_data", done_data, 256'h0);
        tick();
        ch_req = 2'b00;
        tick();

        // Continuous requests from both channels, stray read valids held high
        ch_need_wb = 2'b11; ch_need_fill = 2'b00;
        ch_wb_addr[0 +: AW] = 59'h100;
        ch_wb_addr[1*AW +: AW] = 59'h200;
        ch_wb_data[0 +: DW] = pat_a0;
        ch_wb_data[1*DW +: DW] = pat_b1;
        mem_rd_valid = 1'b1;
        ch_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 2;
            tick();
            if (k > 0) ch_req[(k - 1) % 2] = 1'b1;
            chk("alt_wr_req", 256'(mem_wr_req), 256'(1));
            chk("alt_wr_addr", 256'(mem_wr_base_addr), (g == 0) ? 256'h100 : 256'h200);
            chk("alt_wr_data", mem_wr_data, (g == 0) ? pat_a0 : pat_b1);
            chk("alt_no_rd", 256'(mem_rd_req), 256'(0));
            mem_wr_valid = 1'b1;
            tick();
            mem_wr_valid = 1'b0;
            chk("alt_grant", 256'(ch_done), (g == 0) ? 256'h1 : 256'h2);
            chk("alt_data", done_data, 256'h0);
            chk("alt_no_rd_done", 256'(mem_rd_req), 256'(0));
            tick();
            ch_req[g] = 1'b0;
            chk("alt_idle", 256'(busy), 256'(0));
        end
        mem_rd_valid = 1'b0;
        ch_req = 2'b00;
        tick();
        chk("end_idle", 256'(dbg_state), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
